// File: rtl/palindrome_pkg.sv
// Shared types and constants for the palindrome builder, plus a golden mirror
// function for reference models.
package palindrome_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;
    localparam int MAX_HALF  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Full palindrome of the low h bits of half: {half, bit-reversed half}.
    function automatic logic [2*MAX_HALF-1:0] mirror_ref(input logic [MAX_HALF-1:0] half,
                                                         input int h);
        logic [2*MAX_HALF-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_HALF; i++) begin
            if (i < h) begin
                r[h+i]   = half[i];
                r[h-1-i] = half[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/palindrome_if.sv
// Valid/ready handshake bundle between the palindrome builder and its neighbours:
// half-word in, full palindrome out.
interface palindrome_if
    import palindrome_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    localparam int H = WIDTH / 2;

    logic             in_valid;
    logic             in_ready;
    logic [H-1:0]     in_half;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_word;

    modport master (
        output in_valid, in_half, out_ready,
        input  in_ready, out_valid, out_word
    );

    modport slave (
        input  in_valid, in_half, out_ready,
        output in_ready, out_valid, out_word
    );

endinterface

// File: rtl/palindrome_shifter.sv
// Datapath of the builder: holds the word and mirrors one bit of the upper
// half into the lower half per step.
module palindrome_shifter
    import palindrome_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH/2-1:0] half,
    output logic [WIDTH-1:0]   word,
    output logic               done
);

    localparam int H     = WIDTH / 2;
    localparam int IDX_W = (H > 1) ? $clog2(H) : 1;

    logic [IDX_W-1:0] idx;

    // The upper half already holds in_half, so half[H-1-i] is word[WIDTH-1-i].
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            idx  <= '0;
        end else if (load) begin
            word <= {half, {H{1'b0}}};
            idx  <= '0;
        end else if (step) begin
            for (int i = 0; i < H; i++) begin
                if (idx == IDX_W'(i)) word[i] <= word[WIDTH-1-i];
            end
            idx <= idx + IDX_W'(1);
        end
    end

    assign done = (idx == IDX_W'(H - 1));

endmodule

// File: rtl/palindrome_builder.sv
// Sequential palindrome generator: accepts a half-word, mirrors it bit-serially
// and holds the full palindrome on a valid/ready output.
module palindrome_builder
    import palindrome_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    palindrome_if.slave      bus,
    output logic             busy,
    output logic [CNT_W-1:0] word_count
);

    state_t           state;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             load;
    logic             step;
    logic             done;
    logic [WIDTH-1:0] word;

    // in_ready is high exactly in IDLE, so a load is an IDLE-state accept.
    assign load = (state == IDLE) && bus.in_valid;
    assign step = (state == BUILD);

    palindrome_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .half  (bus.in_half),
        .word  (word),
        .done  (done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            word_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state      <= BUILD;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                BUILD: begin
                    // done marks the final bit being written on this edge.
                    if (done) begin
                        state       <= HOLD;
                        out_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        word_count  <= word_count + CNT_W'(1);
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_valid_q ? word : '0;
    assign busy          = busy_q;

endmodule

// File: tb/tb_palindrome_builder.sv
// Self-checking bench for palindrome_builder across several width/counter
// configurations, compared against a bit-level mirror model.
module tb_palindrome_builder;
    import palindrome_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cnt_model;

    palindrome_if #(.WIDTH(8))  bus8  ();
    palindrome_if #(.WIDTH(8))  busc  ();
    palindrome_if #(.WIDTH(2))  bus2  ();
    palindrome_if #(.WIDTH(16)) bus16 ();

    logic        busy8, buscy, busy2, busy16;
    logic [15:0] cnt8, cnt2, cnt16;
    logic [1:0]  cntc;

    palindrome_builder #(.WIDTH(8), .CNT_W(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8), .busy(busy8), .word_count(cnt8));
    palindrome_builder #(.WIDTH(8), .CNT_W(2)) dutc (
        .clk(clk), .rst_n(rst_n), .bus(busc), .busy(buscy), .word_count(cntc));
    palindrome_builder #(.WIDTH(2), .CNT_W(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .busy(busy2), .word_count(cnt2));
    palindrome_builder #(.WIDTH(16), .CNT_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(bus16), .busy(busy16), .word_count(cnt16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 500000", $time);
        $fatal(1);
    end

    // Selects one configuration: 0 = W8/C16, 1 = W8/C2, 2 = W2, 3 = W16.
    task automatic drive(input int s, input logic v, input logic [7:0] half, input logic ordy);
        bus8.in_valid   = (s == 0) && v;
        bus8.in_half    = (s == 0) ? half[3:0] : 4'h0;
        bus8.out_ready  = (s == 0) && ordy;
        busc.in_valid   = (s == 1) && v;
        busc.in_half    = (s == 1) ? half[3:0] : 4'h0;
        busc.out_ready  = (s == 1) && ordy;
        bus2.in_valid   = (s == 2) && v;
        bus2.in_half    = (s == 2) ? half[0:0] : 1'b0;
        bus2.out_ready  = (s == 2) && ordy;
        bus16.in_valid  = (s == 3) && v;
        bus16.in_half   = (s == 3) ? half : 8'h00;
        bus16.out_ready = (s == 3) && ordy;
    endtask

    function automatic logic o_valid(input int s);
        case (s)
            0: return bus8.out_valid;
            1: return busc.out_valid;
            2: return bus2.out_valid;
            default: return bus16.out_valid;
        endcase
    endfunction

    function automatic logic o_ready(input int s);
        case (s)
            0: return bus8.in_ready;
            1: return busc.in_ready;
            2: return bus2.in_ready;
            default: return bus16.in_ready;
        endcase
    endfunction

    function automatic logic [15:0] o_word(input int s);
        case (s)
            0: return {8'h00, bus8.out_word};
            1: return {8'h00, busc.out_word};
            2: return {14'h0, bus2.out_word};
            default: return bus16.out_word;
        endcase
    endfunction

    function automatic logic [15:0] o_count(input int s);
        case (s)
            0: return cnt8;
            1: return {14'h0, cntc};
            2: return cnt2;
            default: return cnt16;
        endcase
    endfunction

    function automatic logic [15:0] expect_word(input logic [7:0] half, input int h);
        logic [63:0] m;
        m = mirror_ref({24'h0, half}, h);
        return m[15:0];
    endfunction

    // Independent palindrome property, as the downstream checker sees it.
    function automatic logic is_pal(input logic [15:0] w, input int width);
        for (int i = 0; i < width; i++)
            if (w[width-1-i] != w[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Sends one half-word and waits (bounded) for it; returns latency and word.
    task automatic send_word(input int s, input logic [7:0] half,
                             output int lat, output logic [15:0] w);
        int n;
        lat = -1;
        w   = '0;
        checks++;
        if (o_ready(s) !== 1'b1) begin
            errors++;
            $display("FAIL send_ready[%0d]: in_ready=%b required 1", s, o_ready(s));
        end
        drive(s, 1'b1, half, 1'b0);
        @(posedge clk);
        #1;
        drive(s, 1'b0, half, 1'b0);
        n = 0;
        @(negedge clk);
        while (!o_valid(s) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (o_valid(s)) begin
            lat = n;
            w   = o_word(s);
            drive(s, 1'b0, half, 1'b1);
            @(negedge clk);
            drive(s, 1'b0, half, 1'b0);
        end
    endtask

    task automatic test_reset();
        drive(0, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        #12;
        checks++;
        if ({o_ready(0), o_valid(0), busy8} !== 3'b100 || o_word(0) !== 16'h0 || cnt8 !== 16'h0) begin
            errors++;
            $display("FAIL reset_values: ready/valid/busy=%b word=%h count=%0d required 100 0 0",
                     {o_ready(0), o_valid(0), busy8}, o_word(0), cnt8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({o_ready(0), o_valid(0), busy8} !== 3'b100 || o_word(0) !== 16'h0) begin
            errors++;
            $display("FAIL reset_idle: ready/valid/busy=%b word=%h required 100 0",
                     {o_ready(0), o_valid(0), busy8}, o_word(0));
        end
        cnt_model = 0;
    endtask

    task automatic test_single();
        int          lat;
        logic [15:0] w;
        send_word(0, 8'h0B, lat, w);
        checks++;
        if (lat != 4 || w !== 16'h00BD) begin
            errors++;
            $display("FAIL single_word: latency=%0d word=%h required 4 00bd", lat, w);
        end
        cnt_model++;
        checks++;
        if (o_valid(0) !== 1'b0 || o_ready(0) !== 1'b1 || cnt8 !== 16'(cnt_model)) begin
            errors++;
            $display("FAIL single_after: valid=%b ready=%b count=%0d required 0 1 %0d",
                     o_valid(0), o_ready(0), cnt8, cnt_model);
        end
    endtask

    task automatic test_exhaustive();
        int          order[16];
        logic [15:0] q[$];
        logic [15:0] exp;
        int          k, got, last, cyc, j, t;
        for (int i = 0; i < 16; i++) order[i] = i;
        for (int i = 15; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        k = 0; got = 0; last = -1; cyc = 0;
        drive(0, 1'b0, 8'h00, 1'b1);
        while (got < 16 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (o_valid(0)) begin
                exp = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
                checks++;
                if (o_word(0) !== exp || !is_pal(o_word(0), 8)) begin
                    errors++;
                    $display("FAIL exhaustive_word: word=%h required %h", o_word(0), exp);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 6) begin
                        errors++;
                        $display("FAIL exhaustive_period: period=%0d required 6", cyc - last);
                    end
                end
                last = cyc;
                got++;
                cnt_model++;
            end
            if (o_ready(0)) begin
                if (k < 16) begin
                    drive(0, 1'b1, 8'(order[k]), 1'b1);
                    q.push_back(expect_word(8'(order[k]), 4));
                    k++;
                end else begin
                    drive(0, 1'b0, 8'h00, 1'b1);
                end
            end else begin
                // Garbage offered while busy must be ignored.
                drive(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 1'b1);
            end
        end
        checks++;
        if (got != 16) begin
            errors++;
            $display("FAIL exhaustive_timeout: words=%0d required 16", got);
        end
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (cnt8 !== 16'(cnt_model) || o_valid(0) !== 1'b0) begin
            errors++;
            $display("FAIL exhaustive_count: count=%0d valid=%b required %0d 0",
                     cnt8, o_valid(0), cnt_model);
        end
    endtask

    task automatic test_backpressure();
        int   n;
        logic bad;
        @(negedge clk);
        drive(0, 1'b1, 8'h06, 1'b0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 8'h06, 1'b0);
        n = 0;
        while (!o_valid(0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!o_valid(0)) begin
            errors++;
            $display("FAIL backpressure_timeout: out_valid=0 required 1");
        end
        for (int c = 0; c < 10; c++) begin
            drive(0, 1'(c % 2 == 0), 8'h0F, 1'b0);
            @(negedge clk);
            checks++;
            if (o_word(0) !== 16'h0066 || o_ready(0) !== 1'b0 || o_valid(0) !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_hold: word=%h ready=%b valid=%b required 0066 0 1",
                         o_word(0), o_ready(0), o_valid(0));
            end
        end
        drive(0, 1'b0, 8'h00, 1'b1);
        #1;
        checks++;
        if (o_word(0) !== 16'h0066) begin
            errors++;
            $display("FAIL backpressure_deliver: word=%h required 0066", o_word(0));
        end
        @(negedge clk);
        cnt_model++;
        drive(0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (o_valid(0) !== 1'b0 || cnt8 !== 16'(cnt_model)) begin
            errors++;
            $display("FAIL backpressure_count: valid=%b count=%0d required 0 %0d",
                     o_valid(0), cnt8, cnt_model);
        end
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (busy8 !== 1'b0 || o_valid(0) !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL backpressure_no_buffer: a stalled input was consumed, required idle");
        end
    endtask

    task automatic test_reset_mid_build();
        logic bad;
        @(negedge clk);
        drive(0, 1'b1, 8'h09, 1'b0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 8'h09, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_ready(0), o_valid(0), busy8} !== 3'b100 || o_word(0) !== 16'h0 || cnt8 !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_build: ready/valid/busy=%b word=%h count=%0d required 100 0 0",
                     {o_ready(0), o_valid(0), busy8}, o_word(0), cnt8);
        end
        cnt_model = 0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (o_valid(0) !== 1'b0 || busy8 !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || cnt8 !== 16'h0) begin
            errors++;
            $display("FAIL reset_discard: word delivered after reset, count=%0d required 0", cnt8);
        end
    endtask

    task automatic test_wrap();
        int          lat;
        logic [15:0] w;
        logic [7:0]  half;
        for (int n = 1; n <= 5; n++) begin
            half = 8'($urandom_range(0, 15));
            send_word(1, half, lat, w);
            checks++;
            if (lat != 4 || w !== expect_word(half, 4) || o_count(1) !== 16'(n % 4)) begin
                errors++;
                $display("FAIL wrap_%0d: latency=%0d word=%h count=%0d required 4 %h %0d",
                         n, lat, w, o_count(1), expect_word(half, 4), n % 4);
            end
        end
    endtask

    task automatic test_corners();
        int          lat;
        logic [15:0] w;
        logic [7:0]  half;
        send_word(2, 8'h01, lat, w);
        checks++;
        if (lat != 1 || w !== 16'h0003) begin
            errors++;
            $display("FAIL corner_w2: latency=%0d word=%h required 1 0003", lat, w);
        end
        half = 8'($urandom_range(0, 1));
        send_word(2, half, lat, w);
        checks++;
        if (lat != 1 || w !== expect_word(half, 1) || o_count(2) !== 16'd2) begin
            errors++;
            $display("FAIL corner_w2_rand: latency=%0d word=%h count=%0d required 1 %h 2",
                     lat, w, o_count(2), expect_word(half, 1));
        end
        send_word(3, 8'hA5, lat, w);
        checks++;
        if (lat != 8 || w !== 16'hA5A5) begin
            errors++;
            $display("FAIL corner_w16: latency=%0d word=%h required 8 a5a5", lat, w);
        end
        repeat (3) begin
            half = 8'($urandom_range(0, 255));
            send_word(3, half, lat, w);
            checks++;
            if (lat != 8 || w !== expect_word(half, 8) || !is_pal(w, 16)) begin
                errors++;
                $display("FAIL corner_w16_rand: latency=%0d word=%h required 8 %h",
                         lat, w, expect_word(half, 8));
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cnt_model = 0;
        rst_n     = 1'b1;
        drive(0, 1'b0, 8'h00, 1'b0);
        test_reset();
        test_single();
        test_exhaustive();
        test_backpressure();
        test_reset_mid_build();
        test_wrap();
        test_corners();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
